// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. A command is registered onto the ALU inputs, the ALU outputs are
// captured one cycle later, and the result is held on the owner's response port
// until that port consumes it.
module alu_share_arbiter #(
   parameter int unsigned WIDTH      = 32,
   parameter logic [1:0]  IDLE_BTYPE = 2'b11,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0 command
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic [2:0]       req0_op,
   input  logic             req0_binv,
   input  logic [1:0]       req0_btype,
   // requester 1 command
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   input  logic [2:0]       req1_op,
   input  logic             req1_binv,
   input  logic [1:0]       req1_btype,
   // requester 0 response
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic             resp0_cout,
   output logic             resp0_branch,
   // requester 1 response
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic             resp1_cout,
   output logic             resp1_branch,
   // shared ALU
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic             alu_b_inv,
   output logic [2:0]       alu_op,
   output logic [1:0]       alu_btype,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             alu_will_branch,
   // completed-operation counter
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t             state_q, state_d;
   logic               owner_q;
   logic               last_grant_q;
   logic               grant;
   logic               accept;
   logic               consume;

   logic [WIDTH-1:0]   a_q, b_q;
   logic               cin_q, binv_q;
   logic [2:0]         op_q;
   logic [1:0]         btype_q;

   logic [WIDTH-1:0]   res_result_q;
   logic               res_cout_q, res_branch_q;
   logic [CNT_W-1:0]   cnt_q;

   // Grant selection: a lone requester wins; on a tie the port not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign accept     = (state_q == StIdle) && (req0_valid || req1_valid);
   assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
   assign req1_ready = (state_q == StIdle) && req1_valid && grant;
   assign consume    = (state_q == StResp) && (owner_q ? resp1_ready : resp0_ready);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one EXEC cycle, then RESP until the owner consumes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept)  state_d = StExec;
         StExec:              state_d = StResp;
         StResp: if (consume) state_d = StIdle;
         default:             state_d = StIdle;
      endcase
   end

   // Command latch into ALU input registers and arbitration history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         cin_q        <= 1'b0;
         binv_q       <= 1'b0;
         op_q         <= 3'b000;
         btype_q      <= IDLE_BTYPE;
      end else if (accept) begin
         owner_q      <= grant;
         last_grant_q <= grant;
         a_q          <= grant ? req1_a     : req0_a;
         b_q          <= grant ? req1_b     : req0_b;
         cin_q        <= grant ? req1_cin   : req0_cin;
         binv_q       <= grant ? req1_binv  : req0_binv;
         op_q         <= grant ? req1_op    : req0_op;
         btype_q      <= grant ? req1_btype : req0_btype;
      end else if (consume) begin
         // Only the branch type reverts so an idle ALU never signals a branch.
         btype_q      <= IDLE_BTYPE;
      end
   end

   // Response capture at the end of EXEC and consumed-operation counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_result_q <= '0;
         res_cout_q   <= 1'b0;
         res_branch_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (state_q == StExec) begin
            res_result_q <= alu_result;
            res_cout_q   <= alu_cout;
            res_branch_q <= alu_will_branch;
         end
         if (consume) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_cin   = cin_q;
   assign alu_b_inv = binv_q;
   assign alu_op    = op_q;
   assign alu_btype = btype_q;

   // Both ports share the response registers; only valid is owner-specific.
   assign resp0_valid  = (state_q == StResp) && !owner_q;
   assign resp1_valid  = (state_q == StResp) && owner_q;
   assign resp0_result = res_result_q;
   assign resp0_cout   = res_cout_q;
   assign resp0_branch = res_branch_q;
   assign resp1_result = res_result_q;
   assign resp1_cout   = res_cout_q;
   assign resp1_branch = res_branch_q;

   assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a behavioural ALU behind the DUT and
// per-port scoreboards filled on command handshakes, drained on response handshakes.
module tb_alu_share_arbiter;

   localparam int unsigned CW = 10;  // narrow counter keeps the wrap test short

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_cin, req0_binv;
   logic [31:0] req0_a, req0_b;
   logic [2:0]  req0_op;
   logic [1:0]  req0_btype;
   logic        req1_valid, req1_ready, req1_cin, req1_binv;
   logic [31:0] req1_a, req1_b;
   logic [2:0]  req1_op;
   logic [1:0]  req1_btype;
   logic        resp0_valid, resp0_ready, resp0_cout, resp0_branch;
   logic [31:0] resp0_result;
   logic        resp1_valid, resp1_ready, resp1_cout, resp1_branch;
   logic [31:0] resp1_result;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_cin, alu_b_inv, alu_cout, alu_will_branch;
   logic [2:0]  alu_op;
   logic [1:0]  alu_btype;
   logic [CW-1:0] op_count;
   logic [33:0] alu_out;

   int checks = 0;
   int errors = 0;
   int consumed = 0;
   logic [33:0] exp0_q[$];
   logic [33:0] exp1_q[$];
   int grant_q[$];
   logic [31:0] last_res0, last_res1;
   logic        last_br0;
   int resp_seen0, resp_seen1;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .IDLE_BTYPE(2'b11), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cin(req0_cin), .req0_op(req0_op), .req0_binv(req0_binv), .req0_btype(req0_btype),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cin(req1_cin), .req1_op(req1_op), .req1_binv(req1_binv), .req1_btype(req1_btype),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
      .resp0_cout(resp0_cout), .resp0_branch(resp0_branch),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
      .resp1_cout(resp1_cout), .resp1_branch(resp1_branch),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_b_inv(alu_b_inv),
      .alu_op(alu_op), .alu_btype(alu_btype), .alu_result(alu_result),
      .alu_cout(alu_cout), .alu_will_branch(alu_will_branch), .op_count(op_count)
   );

   // Behavioural ALU: {willBranch, Cout, Result}.
   function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic [2:0] op,
                                           input logic binv, input logic [1:0] bt);
      logic [31:0] bb;
      logic [32:0] sum;
      logic [31:0] r;
      logic        br;
      bb  = binv ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {32'b0, cin};
      case (op)
         3'b000:  r = a & bb;
         3'b001:  r = a | bb;
         3'b010:  r = sum[31:0];
         3'b011:  r = a << bb[4:0];
         default: r = a ^ bb;
      endcase
      if (bt == 2'b10)      br = a[31];
      else if (bt == 2'b00) br = (r == 32'b0);
      else                  br = 1'b0;
      return {br, sum[32], r};
   endfunction

   always_comb alu_out = alu_ref(alu_a, alu_b, alu_cin, alu_op, alu_b_inv, alu_btype);
   assign alu_result      = alu_out[31:0];
   assign alu_cout        = alu_out[32];
   assign alu_will_branch = alu_out[33];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observes the handshakes that will complete on the upcoming rising edge.
   task automatic monitor();
      logic [33:0] e;
      chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
      chk("one_resp_valid", 64'(resp0_valid & resp1_valid), 64'd0);
      if (req0_valid && req0_ready) begin
         exp0_q.push_back(alu_ref(req0_a, req0_b, req0_cin, req0_op, req0_binv, req0_btype));
         if (grant_q.size() > 0) chk("grant_order", 64'd0, 64'(grant_q.pop_front()));
      end
      if (req1_valid && req1_ready) begin
         exp1_q.push_back(alu_ref(req1_a, req1_b, req1_cin, req1_op, req1_binv, req1_btype));
         if (grant_q.size() > 0) chk("grant_order", 64'd1, 64'(grant_q.pop_front()));
      end
      if (resp0_valid && resp0_ready) begin
         if (exp0_q.size() == 0) begin
            chk("resp0_unexpected", 64'(resp0_valid), 64'd0);
         end else begin
            e = exp0_q.pop_front();
            chk("resp0_result", 64'(resp0_result), 64'(e[31:0]));
            chk("resp0_cout", 64'(resp0_cout), 64'(e[32]));
            chk("resp0_branch", 64'(resp0_branch), 64'(e[33]));
         end
         last_res0 = resp0_result;
         last_br0  = resp0_branch;
         resp_seen0++;
         consumed++;
      end
      if (resp1_valid && resp1_ready) begin
         if (exp1_q.size() == 0) begin
            chk("resp1_unexpected", 64'(resp1_valid), 64'd0);
         end else begin
            e = exp1_q.pop_front();
            chk("resp1_result", 64'(resp1_result), 64'(e[31:0]));
            chk("resp1_cout", 64'(resp1_cout), 64'(e[32]));
            chk("resp1_branch", 64'(resp1_branch), 64'(e[33]));
         end
         last_res1 = resp1_result;
         resp_seen1++;
         consumed++;
      end
   endtask

   // One cycle: inputs change right after a falling edge, sampled 2 ns later.
   task automatic step();
      #2;
      monitor();
      @(negedge clk);
   endtask

   task automatic wait_consume(input string tag, input int budget);
      int n0;
      int i;
      n0 = consumed;
      i  = 0;
      while (consumed == n0 && i < budget) begin
         step();
         i++;
      end
      chk(tag, 64'(consumed - n0), 64'd1);
   endtask

   task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [2:0] op, input logic binv, input logic [1:0] bt);
      req0_a = a; req0_b = b; req0_cin = cin; req0_op = op; req0_binv = binv; req0_btype = bt;
   endtask

   task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [2:0] op, input logic binv, input logic [1:0] bt);
      req1_a = a; req1_b = b; req1_cin = cin; req1_op = op; req1_binv = binv; req1_btype = bt;
   endtask

   initial begin
      int steps;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      set0(32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 2'b11);
      set1(32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 2'b11);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      resp_seen0 = 0; resp_seen1 = 0;
      last_res0 = '0; last_res1 = '0; last_br0 = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_resp0_valid", 64'(resp0_valid), 64'd0);
      chk("rst_resp1_valid", 64'(resp1_valid), 64'd0);
      chk("rst_alu_btype", 64'(alu_btype), 64'd3);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_result", 64'(resp0_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention: port 0 wins the first tie, then strict alternation
      set0(32'd17, 32'd5, 1'b0, 3'b010, 1'b0, 2'b11);
      set1(32'd0, 32'd5, 1'b1, 3'b010, 1'b1, 2'b11);
      req0_valid = 1'b1; req1_valid = 1'b1;
      grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
      repeat (12) step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("cont_grants_left", 64'(grant_q.size()), 64'd0);
      chk("cont_resp0_count", 64'(resp_seen0), 64'd2);
      chk("cont_resp1_count", 64'(resp_seen1), 64'd2);
      chk("cont_res0", 64'(last_res0), 64'd22);
      chk("cont_res1", 64'(last_res1), 64'hFFFF_FFFB);
      chk("cont_op_count", 64'(op_count), 64'd4);

      // Single add with cycle-exact latency
      set0(32'd4, 32'd5, 1'b0, 3'b010, 1'b0, 2'b11);
      req0_valid = 1'b1;
      #1;
      chk("add_ready_c0", 64'(req0_ready), 64'd1);
      step();
      req0_valid = 1'b0;
      #1;
      chk("add_valid_c1", 64'(resp0_valid), 64'd0);
      step();
      #1;
      chk("add_valid_c2", 64'(resp0_valid), 64'd1);
      chk("add_result", 64'(resp0_result), 64'd9);
      chk("add_branch", 64'(resp0_branch), 64'd0);
      step();
      #1;
      chk("add_op_count", 64'(op_count), 64'(consumed % (1 << CW)));
      chk("add_op_count_abs", 64'(op_count), 64'd5);

      // Backpressure on port 1 while port 0 waits
      set1(32'd4, 32'd5, 1'b0, 3'b000, 1'b0, 2'b11);
      resp1_ready = 1'b0;
      req1_valid  = 1'b1;
      #1;
      chk("bp_req1_ready", 64'(req1_ready), 64'd1);
      step();
      req1_valid = 1'b0;
      set0(32'd1, 32'd1, 1'b0, 3'b010, 1'b0, 2'b11);
      req0_valid = 1'b1;
      #1;
      chk("bp_req0_ready_exec", 64'(req0_ready), 64'd0);
      step();
      repeat (5) begin
         #1;
         chk("bp_resp1_valid", 64'(resp1_valid), 64'd1);
         chk("bp_resp1_result", 64'(resp1_result), 64'd4);
         chk("bp_req0_ready", 64'(req0_ready), 64'd0);
         step();
      end
      resp1_ready = 1'b1;
      step();
      #1;
      chk("bp_req0_ready_after", 64'(req0_ready), 64'd1);
      step();
      req0_valid = 1'b0;
      wait_consume("bp_port0_timeout", 10);
      chk("bp_queues_empty", 64'(exp0_q.size() + exp1_q.size()), 64'd0);

      // Branch on negative A, then no branch on positive A
      set0(-32'sd5, 32'd0, 1'b0, 3'b010, 1'b0, 2'b10);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      wait_consume("br_neg_timeout", 10);
      chk("br_neg", 64'(last_br0), 64'd1);
      #1;
      chk("br_btype_idle", 64'(alu_btype), 64'd3);
      chk("br_alu_a_held", 64'(alu_a), 64'hFFFF_FFFB);
      set0(32'd5, 32'd0, 1'b0, 3'b010, 1'b0, 2'b10);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      wait_consume("br_pos_timeout", 10);
      chk("br_pos", 64'(last_br0), 64'd0);

      // Reset asserted in EXEC drops the command
      set0(32'd7, 32'd8, 1'b0, 3'b010, 1'b0, 2'b10);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_resp0_valid", 64'(resp0_valid), 64'd0);
      chk("mid_rst_btype", 64'(alu_btype), 64'd3);
      chk("mid_rst_op_count", 64'(op_count), 64'd0);
      chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
      exp0_q.delete();
      exp1_q.delete();
      consumed = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step();
      #1;
      chk("mid_rst_no_stale", 64'(resp0_valid | resp1_valid), 64'd0);

      // Single requester served every 3 cycles, then counter wrap
      set0(32'd1, 32'd2, 1'b0, 3'b010, 1'b0, 2'b11);
      req0_valid = 1'b1;
      steps = 0;
      while (consumed < (1 << CW) - 1 && steps < 4 * (1 << CW)) begin
         step();
         steps++;
      end
      chk("wrap_issue_interval", 64'(steps), 64'(3 * ((1 << CW) - 2) + 3));
      chk("wrap_pre", 64'(op_count), 64'((1 << CW) - 1));
      wait_consume("wrap_timeout", 10);
      req0_valid = 1'b0;
      chk("wrap_post", 64'(op_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
